data_ram_arbiter: RTL and testbench

Two-master arbiter that shares the single-port data RAM between the OpenMIPS data port (master CPU) and an external loader/debug port (master EXT). It sits in the minimal SOPC between the core's `ram_*` bus and `data_ram`. Ownership is parked on the CPU, so the CPU pays no latency while EXT is idle. EXT gets bounded bursts, with an anti-starvation counter guaranteeing it service under continuous CPU load.

---
 rtl/data_ram_arbiter_pkg.sv | 27 ++
 rtl/data_ram_arbiter.sv | 106 ++++++++++
 tb/tb_data_ram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_arbiter_pkg.sv
// Shared types for the data RAM arbiter: bus width, 4-bit state/counter encodings,
// the RAM request bundle and a saturating counter helper.
package data_ram_arbiter_pkg;

    localparam int REG_W = 32;
    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [CNT_W-1:0] {
        ARB_CPU = 4'd0,
        ARB_EXT = 4'd1
    } arb_state_e;

    typedef struct packed {
        logic             ce;
        logic             we;
        logic [REG_W-1:0] addr;
        logic [3:0]       sel;
        logic [REG_W-1:0] data;
    } ram_req_t;

    function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim);
        return (v >= lim) ? lim : cnt_t'(v + 1'b1);
    endfunction

endpackage

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU owns the bus by default,
// EXT gets capped bursts and is forced in after STARVE_LIMIT blocked cycles.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int EXT_BURST    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_ce_i,
    input  logic             cpu_we_i,
    input  logic [REG_W-1:0] cpu_addr_i,
    input  logic [3:0]       cpu_sel_i,
    input  logic [REG_W-1:0] cpu_data_i,
    output logic [REG_W-1:0] cpu_data_o,
    output logic             cpu_stallreq_o,
    input  logic             ext_req_i,
    input  logic             ext_we_i,
    input  logic [REG_W-1:0] ext_addr_i,
    input  logic [3:0]       ext_sel_i,
    input  logic [REG_W-1:0] ext_data_i,
    output logic             ext_ack_o,
    output logic [REG_W-1:0] ext_data_o,
    output logic             ram_ce_o,
    output logic             ram_we_o,
    output logic [REG_W-1:0] ram_addr_o,
    output logic [3:0]       ram_sel_o,
    output logic [REG_W-1:0] ram_data_o,
    input  logic [REG_W-1:0] ram_data_i
);

    localparam cnt_t STARVE_LIM = cnt_t'(STARVE_LIMIT);
    localparam cnt_t BURST_LAST = cnt_t'(EXT_BURST - 1);
    localparam cnt_t CNT_MAX    = '1;

    arb_state_e state;
    cnt_t       starve_cnt;
    cnt_t       burst_cnt;
    ram_req_t   cpu_req, ext_req, bus;
    logic       ack, stall;

    assign cpu_req = '{ce: cpu_ce_i, we: cpu_ce_i & cpu_we_i, addr: cpu_addr_i,
                       sel: cpu_sel_i, data: cpu_data_i};
    assign ext_req = '{ce: ext_req_i, we: ext_req_i & ext_we_i, addr: ext_addr_i,
                       sel: ext_sel_i, data: ext_data_i};

    // Reset gates the bus so nothing reaches the RAM while rst is low.
    always_comb begin
        bus   = '0;
        ack   = 1'b0;
        stall = 1'b0;
        if (rst) begin
            if (state == ARB_EXT) begin
                bus   = ext_req;
                ack   = ext_req_i;
                stall = cpu_ce_i;
            end else begin
                bus = cpu_req;
            end
        end
    end

    assign ram_ce_o       = bus.ce;
    assign ram_we_o       = bus.we;
    assign ram_addr_o     = bus.addr;
    assign ram_sel_o      = bus.sel;
    assign ram_data_o     = bus.data;
    assign ext_ack_o      = ack;
    assign cpu_stallreq_o = stall;
    assign cpu_data_o     = ram_data_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_CPU;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            ext_data_o <= '0;
        end else begin
            case (state)
                ARB_CPU: begin
                    if (ext_req_i && (!cpu_ce_i || starve_cnt == STARVE_LIM)) begin
                        state      <= ARB_EXT;
                        starve_cnt <= '0;
                        burst_cnt  <= '0;
                    end else if (ext_req_i) begin
                        starve_cnt <= sat_inc(starve_cnt, STARVE_LIM);
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ARB_EXT: begin
                    // Saturate so a long free burst cannot wrap and re-extend a later CPU stall.
                    if (ext_req_i)
                        burst_cnt <= sat_inc(burst_cnt, CNT_MAX);
                    if (!(ext_req_i && (!cpu_ce_i || burst_cnt < BURST_LAST)))
                        state <= ARB_CPU;
                end
                default: state <= ARB_CPU;
            endcase
            if (ack && !ext_we_i)
                ext_data_o <= ram_data_i;
        end
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomized and directed bench for data_ram_arbiter against a cycle-level
// ownership model with a shadow copy of the RAM contents.
module tb_data_ram_arbiter;

    localparam int SL = 4;
    localparam int EB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic [3:0]  cpu_sel_i;
    logic        cpu_stallreq_o;
    logic        ext_req_i, ext_we_i;
    logic [31:0] ext_addr_i, ext_data_i, ext_data_o;
    logic [3:0]  ext_sel_i;
    logic        ext_ack_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
    logic [3:0]  ram_sel_o;

    always #5 clk = ~clk;

    data_ram_arbiter #(.STARVE_LIMIT(SL), .EXT_BURST(EB)) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .cpu_stallreq_o(cpu_stallreq_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
        .ext_sel_i(ext_sel_i), .ext_data_i(ext_data_i), .ext_ack_o(ext_ack_o),
        .ext_data_o(ext_data_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
    );

    // Behavioural data RAM: combinational read, byte-lane write on the clock edge.
    logic [31:0] mem [256];
    logic        mem_init;

    function automatic logic [31:0] seed(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    assign ram_data_i = mem[ram_addr_o[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
        end else if (ram_ce_o && ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
        end
    end

    // Reference model: who owns the RAM, how long EXT has waited, how many
    // accesses EXT has made in its current tenure, and the expected RAM contents.
    int          m_own, m_starve, m_burst;
    logic [31:0] m_xd;
    logic [31:0] shadow [256];
    int          vec = 0, err = 0;
    logic        obs_ack, obs_stall, obs_ce;
    logic [31:0] obs_xd;

    function automatic logic [31:0] rnd_addr();
        return {22'd0, 8'($urandom), 2'b00};
    endfunction

    // One clock: compare outputs against the model, then advance the model at the edge.
    task automatic step(input string tag);
        logic        e_ce, e_we, e_ack, e_stall;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_sel;
        int          idx;
        #1;
        if (!rst) begin
            m_own = 0; m_starve = 0; m_burst = 0; m_xd = '0;
        end
        e_ce = 0; e_we = 0; e_ack = 0; e_stall = 0; e_addr = '0; e_wd = '0; e_sel = '0;
        if (rst && m_own == 1) begin
            e_ce = ext_req_i; e_we = ext_req_i & ext_we_i; e_addr = ext_addr_i;
            e_sel = ext_sel_i; e_wd = ext_data_i; e_ack = ext_req_i; e_stall = cpu_ce_i;
        end else if (rst) begin
            e_ce = cpu_ce_i; e_we = cpu_ce_i & cpu_we_i; e_addr = cpu_addr_i;
            e_sel = cpu_sel_i; e_wd = cpu_data_i;
        end
        idx  = int'(e_addr[9:2]);
        e_rd = shadow[idx];
        vec += 9;
        if (ram_ce_o !== e_ce) begin err++; $display("FAIL %s ram_ce got %b want %b", tag, ram_ce_o, e_ce); end
        if (ram_we_o !== e_we) begin err++; $display("FAIL %s ram_we got %b want %b", tag, ram_we_o, e_we); end
        if (ram_addr_o !== e_addr) begin err++; $display("FAIL %s ram_addr got %h want %h", tag, ram_addr_o, e_addr); end
        if (ram_sel_o !== e_sel) begin err++; $display("FAIL %s ram_sel got %h want %h", tag, ram_sel_o, e_sel); end
        if (ram_data_o !== e_wd) begin err++; $display("FAIL %s ram_data got %h want %h", tag, ram_data_o, e_wd); end
        if (ext_ack_o !== e_ack) begin err++; $display("FAIL %s ext_ack got %b want %b", tag, ext_ack_o, e_ack); end
        if (cpu_stallreq_o !== e_stall) begin err++; $display("FAIL %s stall got %b want %b", tag, cpu_stallreq_o, e_stall); end
        if (ext_data_o !== m_xd) begin err++; $display("FAIL %s ext_data got %h want %h", tag, ext_data_o, m_xd); end
        if (cpu_data_o !== e_rd) begin err++; $display("FAIL %s cpu_data got %h want %h", tag, cpu_data_o, e_rd); end
        obs_ack = ext_ack_o; obs_stall = cpu_stallreq_o; obs_ce = ram_ce_o; obs_xd = ext_data_o;
        @(posedge clk);
        if (rst) begin
            if (e_ce && e_we)
                for (int b = 0; b < 4; b++)
                    if (e_sel[b]) shadow[idx][8*b +: 8] = e_wd[8*b +: 8];
            if (e_ack && !ext_we_i) m_xd = e_rd;
            if (m_own == 0) begin
                if (ext_req_i && (!cpu_ce_i || m_starve >= SL)) begin
                    m_own = 1; m_starve = 0; m_burst = 0;
                end else begin
                    m_starve = ext_req_i ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                end
            end else begin
                if (ext_req_i) m_burst++;
                // EXT keeps the RAM while it asks, unless a waiting CPU has sat out EB accesses.
                if (!ext_req_i || (cpu_ce_i && m_burst >= EB)) m_own = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic cpu_idle();
        cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    endtask

    task automatic ext_set(input logic we, input logic [31:0] a, input logic [31:0] d);
        ext_req_i = 1; ext_we_i = we; ext_addr_i = a; ext_sel_i = 4'hF; ext_data_i = d;
    endtask

    task automatic ext_off();
        ext_req_i = 0; ext_we_i = 0; ext_addr_i = '0; ext_sel_i = '0; ext_data_i = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) shadow[i] = seed(i);
        cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h24; cpu_sel_i = 4'hF; cpu_data_i = 32'h1234_5678;
        ext_set(1'b1, 32'h80, 32'hCAFE_F00D);
        repeat (3) step("reset");
        vec++;
        if (obs_ce !== 1'b0 || obs_ack !== 1'b0) begin
            err++; $display("FAIL reset_outputs ce/ack got %b/%b want 0/0", obs_ce, obs_ack);
        end
        mem_init = 0; rst = 1;
        ext_off(); cpu_we_i = 0;
        step("post_reset");
        vec++;
        if (obs_ce !== 1'b1) begin err++; $display("FAIL post_reset_cpu_pass ce got %b want 1", obs_ce); end
        cpu_idle();
        step("post_reset_idle");
    endtask

    task automatic test_ext_idle();
        cpu_idle();
        ext_set(1'b1, 32'h40, 32'hDEAD_BEEF);
        step("ext_idle_c1");
        vec++;
        if (obs_ack !== 1'b0) begin err++; $display("FAIL ext_idle_c1 ack got %b want 0", obs_ack); end
        step("ext_idle_c2");
        vec++;
        if (obs_ack !== 1'b1) begin err++; $display("FAIL ext_idle_c2 ack got %b want 1", obs_ack); end
        ext_set(1'b0, 32'h40, 32'h0);
        step("ext_read");
        ext_off();
        step("ext_drop");
        vec += 2;
        if (obs_xd !== 32'hDEAD_BEEF) begin err++; $display("FAIL ext_readback got %h want deadbeef", obs_xd); end
        if (obs_ce !== 1'b0) begin err++; $display("FAIL ext_drop ram_ce got %b want 0", obs_ce); end
        step("ext_idle_tail");
    endtask

    task automatic test_starve();
        ext_off(); cpu_idle();
        step("starve_pre");
        cpu_ce_i = 1; cpu_addr_i = 32'h10; cpu_sel_i = 4'hF;
        ext_set(1'b1, 32'h44, 32'h0BAD_CAFE);
        for (int c = 1; c <= SL + 1; c++) begin
            step("starve_wait");
            vec++;
            if (obs_ack !== 1'b0 || obs_stall !== 1'b0) begin
                err++; $display("FAIL starve_wait c%0d ack/stall got %b/%b want 0/0", c, obs_ack, obs_stall);
            end
        end
        step("starve_grant");
        vec++;
        if (obs_ack !== 1'b1 || obs_stall !== 1'b1) begin
            err++; $display("FAIL starve_grant ack/stall got %b/%b want 1/1", obs_ack, obs_stall);
        end
        ext_off();
        step("starve_tail");
    endtask

    task automatic test_burst_cap();
        int acks = 0, run = 0, max_run = 0, stall_run = 0, max_stall = 0;
        ext_off(); cpu_idle();
        step("burst_pre");
        cpu_ce_i = 1;
        ext_set(1'b1, rnd_addr(), $urandom);
        for (int c = 0; c < 40 && acks < 6; c++) begin
            cpu_addr_i = rnd_addr(); cpu_we_i = 1'($urandom); cpu_sel_i = 4'($urandom); cpu_data_i = $urandom;
            step("burst");
            stall_run = obs_stall ? stall_run + 1 : 0;
            run       = obs_ack ? run + 1 : 0;
            if (stall_run > max_stall) max_stall = stall_run;
            if (run > max_run) max_run = run;
            if (obs_ack) begin
                acks++;
                if (acks < 6) ext_set(1'b1, rnd_addr(), $urandom);
                else ext_off();
            end
        end
        vec += 3;
        if (acks !== 6) begin err++; $display("FAIL burst_acks got %0d want 6", acks); end
        if (max_run !== EB) begin err++; $display("FAIL burst_run got %0d want %0d", max_run, EB); end
        if (max_stall > EB) begin err++; $display("FAIL burst_stall got %0d want <=%0d", max_stall, EB); end
        ext_off(); cpu_idle();
        step("burst_tail");
    endtask

    task automatic test_free_burst();
        int run = 0, max_run = 0;
        ext_off(); cpu_idle();
        step("free_pre");
        ext_set(1'b0, rnd_addr(), '0);
        for (int c = 0; c < 12; c++) begin
            step("free");
            run = obs_ack ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (obs_ack) begin
                if (run < 8) ext_set(1'b0, rnd_addr(), '0);
                else ext_off();
            end
        end
        vec++;
        if (max_run !== 8) begin err++; $display("FAIL free_burst_run got %0d want 8", max_run); end
    endtask

    task automatic test_reset_mid();
        ext_off(); cpu_idle();
        step("rmid_pre");
        ext_set(1'b1, rnd_addr(), $urandom);
        step("rmid_switch");
        step("rmid_ack");
        rst = 0; cpu_ce_i = 1; cpu_addr_i = 32'h10; cpu_sel_i = 4'hF;
        step("rmid_reset");
        vec++;
        if (obs_ack !== 1'b0) begin err++; $display("FAIL reset_mid ack got %b want 0", obs_ack); end
        rst = 1;
        repeat (8) step("rmid_rearb");
        ext_off(); cpu_idle();
        step("rmid_tail");
    endtask

    task automatic test_random();
        ext_off(); cpu_idle();
        for (int c = 0; c < 400; c++) begin
            cpu_ce_i = ($urandom_range(0, 9) < 6); cpu_we_i = 1'($urandom);
            cpu_addr_i = rnd_addr(); cpu_sel_i = 4'($urandom); cpu_data_i = $urandom;
            if (!ext_req_i) begin
                if ($urandom_range(0, 9) < 3) ext_set(1'($urandom), rnd_addr(), $urandom);
            end else if (obs_ack) begin
                if ($urandom_range(0, 1) == 0) ext_set(1'($urandom), rnd_addr(), $urandom);
                else ext_off();
            end
            if (ext_req_i) ext_sel_i = 4'($urandom);
            step("random");
        end
    endtask

    initial begin
        mem_init = 1; rst = 0;
        m_own = 0; m_starve = 0; m_burst = 0; m_xd = '0;
        obs_ack = 0; obs_stall = 0; obs_ce = 0; obs_xd = '0;
        cpu_idle(); ext_off();
        @(negedge clk);
        test_reset();
        test_ext_idle();
        test_starve();
        test_burst_cap();
        test_free_burst();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
